// File: rtl/fir_mac_sequencer.sv
// Control sequencer for a time-multiplexed FIR filter. It captures samples, writes them
// into a circular buffer, steps TAP MAC cycles per sample and arbitrates coefficient writes.
module fir_mac_sequencer #(
  parameter  int TAP     = 8,
  parameter  int DW      = 16,
  parameter  int MAC_LAT = 2,
  localparam int AW      = $clog2(TAP)
) (
  input  logic          clk_filter,
  input  logic          rst_n,
  // sample stream
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  // sample buffer ports
  output logic          smp_we,
  output logic [AW-1:0] smp_waddr,
  output logic [DW-1:0] smp_wdata,
  output logic [AW-1:0] smp_raddr,
  // coefficient read and accumulator control
  output logic [AW-1:0] coef_raddr,
  output logic          acc_clr,
  output logic          acc_en,
  output logic          out_valid,
  output logic          busy,
  // coefficient configuration
  input  logic          cfg_we,
  input  logic [AW-1:0] cfg_addr,
  input  logic [DW-1:0] cfg_data,
  output logic          cfg_ack,
  output logic          coef_we,
  output logic [AW-1:0] coef_waddr,
  output logic [DW-1:0] coef_wdata
);

  localparam int DLW = $clog2(MAC_LAT + 2);

  localparam logic [AW-1:0]  K_LAST = AW'(TAP - 1);
  localparam logic [DLW-1:0] D_LAST = DLW'((MAC_LAT > 0) ? MAC_LAT - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t         state, state_nxt;
  logic [AW-1:0]  wptr;
  logic [AW-1:0]  k;
  logic [DLW-1:0] d;
  logic [DW-1:0]  sreg;

  logic           accept;
  logic [AW-1:0]  rd_addr;

  // Config owns the IDLE cycle it arrives in; the sample simply waits one cycle.
  assign in_ready = (state == S_IDLE) && !cfg_we;
  assign accept   = in_valid && in_ready;
  assign busy     = (state != S_IDLE);

  assign cfg_ack    = (state == S_IDLE) && cfg_we;
  assign coef_we    = cfg_ack;
  assign coef_waddr = cfg_ack ? cfg_addr : '0;
  assign coef_wdata = cfg_ack ? cfg_data : '0;

  // (wptr - k) mod TAP without relying on 2^AW wrap: when wptr < k the value is
  // wptr + (TAP-1-k) + 1, whose terms never underflow and whose sum stays below TAP.
  assign rd_addr = (wptr < k) ? (wptr + (K_LAST - k) + 1'b1) : (wptr - k);

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (accept) state_nxt = S_LOAD;
      S_LOAD:  state_nxt = S_RUN;
      S_RUN:   if (k == K_LAST) state_nxt = (MAC_LAT == 0) ? S_DONE : S_DRAIN;
      S_DRAIN: if (d == D_LAST) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk_filter or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      wptr  <= '0;
      k     <= '0;
      d     <= '0;
      sreg  <= '0;
    end else begin
      state <= state_nxt;
      unique case (state)
        S_IDLE: if (accept) sreg <= in_data;
        S_LOAD: k <= '0;
        S_RUN: begin
          if (k == K_LAST) begin
            wptr <= (wptr == K_LAST) ? '0 : wptr + 1'b1;
            k    <= '0;
            d    <= '0;
          end else begin
            k <= k + 1'b1;
          end
        end
        S_DRAIN: d <= d + 1'b1;
        default: ;
      endcase
    end
  end

  // NOTE: every output gets its inactive value before the case, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    smp_we     = 1'b0;
    smp_waddr  = '0;
    smp_wdata  = '0;
    smp_raddr  = '0;
    coef_raddr = '0;
    acc_clr    = 1'b0;
    acc_en     = 1'b0;
    out_valid  = 1'b0;
    unique case (state)
      S_LOAD: begin
        smp_we    = 1'b1;
        smp_waddr = wptr;
        smp_wdata = sreg;
      end
      S_RUN: begin
        acc_en     = 1'b1;
        acc_clr    = (k == '0);
        coef_raddr = k;
        smp_raddr  = rd_addr;
      end
      S_DONE:  out_valid = 1'b1;
      default: ;
    endcase
  end

endmodule
